// File: rtl/ysyx_23060075_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI-lite arbiter.
// One transaction at a time; the grant is held until the response handshake completes.
module ysyx_23060075_axi_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // m0: IFU, read only
  input  logic [DATA_WIDTH-1:0] m0_araddr,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [DATA_WIDTH-1:0] m0_rresp,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  // m1: LSU, read and write
  input  logic [DATA_WIDTH-1:0] m1_araddr,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [DATA_WIDTH-1:0] m1_rresp,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  input  logic [DATA_WIDTH-1:0] m1_awaddr,
  input  logic                  m1_awvalid,
  output logic                  m1_awready,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic [MASK_WIDTH-1:0] m1_wstrb,
  input  logic                  m1_wvalid,
  output logic                  m1_wready,
  output logic [DATA_WIDTH-1:0] m1_bresp,
  output logic                  m1_bvalid,
  input  logic                  m1_bready,
  // s: towards the crossbar
  output logic [DATA_WIDTH-1:0] s_araddr,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [DATA_WIDTH-1:0] s_rresp,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  output logic [DATA_WIDTH-1:0] s_awaddr,
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [DATA_WIDTH-1:0] s_wdata,
  output logic [MASK_WIDTH-1:0] s_wstrb,
  output logic                  s_wvalid,
  input  logic                  s_wready,
  input  logic [DATA_WIDTH-1:0] s_bresp,
  input  logic                  s_bvalid,
  output logic                  s_bready,
  // debug view of the grant state
  output logic [1:0]            st_dbg
);

  // Handshake rule on every channel: a transfer happens on the rising edge where
  // valid and ready are both high; valid, once raised, stays high until that edge.

  typedef enum logic [1:0] {IDLE = 2'd0, G0R = 2'd1, G1R = 2'd2, G1W = 2'd3} st_t;

  st_t  st, st_nxt;
  logic last, last_nxt;
  logic r0, r1;

  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= IDLE;
      last <= 1'b1;
    end else begin
      st   <= st_nxt;
      last <= last_nxt;
    end
  end

  assign r0 = m0_arvalid;
  assign r1 = m1_arvalid | m1_awvalid;
  assign st_dbg = st;

  always_comb begin
    st_nxt   = st;
    last_nxt = last;
    unique case (st)
      IDLE: begin
        // m0 wins when alone or when m1 had the previous grant.
        if (r0 && (!r1 || last)) begin
          st_nxt   = G0R;
          last_nxt = 1'b0;
        end else if (r1) begin
          st_nxt   = m1_arvalid ? G1R : G1W;
          last_nxt = 1'b1;
        end
      end
      G0R, G1R: if (s_rvalid && s_rready) st_nxt = IDLE;
      G1W:      if (s_bvalid && s_bready) st_nxt = IDLE;
      default:  st_nxt = IDLE;
    endcase
  end

  always_comb begin
    m0_arready = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bresp   = '0;
    m1_bvalid  = 1'b0;
    s_araddr   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awaddr   = '0;
    s_awvalid  = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    unique case (st)
      G0R: begin
        s_araddr   = m0_araddr;
        s_arvalid  = m0_arvalid;
        m0_arready = s_arready;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        m0_rvalid  = s_rvalid;
        s_rready   = m0_rready;
      end
      G1R: begin
        s_araddr   = m1_araddr;
        s_arvalid  = m1_arvalid;
        m1_arready = s_arready;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
        m1_rvalid  = s_rvalid;
        s_rready   = m1_rready;
      end
      G1W: begin
        s_awaddr   = m1_awaddr;
        s_awvalid  = m1_awvalid;
        m1_awready = s_awready;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wvalid   = m1_wvalid;
        m1_wready  = s_wready;
        m1_bresp   = s_bresp;
        m1_bvalid  = s_bvalid;
        s_bready   = m1_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060075_axi_arbiter.sv
// Directed bench for the AXI-lite arbiter; the bench plays both masters and the slave.
module tb_ysyx_23060075_axi_arbiter;

  localparam logic [1:0] IDLE = 2'd0, G0R = 2'd1, G1R = 2'd2, G1W = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m0_araddr = '0, m0_rdata, m0_rresp;
  logic        m0_arvalid = 1'b0, m0_arready, m0_rvalid, m0_rready = 1'b1;
  logic [31:0] m1_araddr = '0, m1_rdata, m1_rresp, m1_awaddr = '0, m1_wdata = '0, m1_bresp;
  logic [3:0]  m1_wstrb = '0;
  logic        m1_arvalid = 1'b0, m1_arready, m1_rvalid, m1_rready = 1'b1;
  logic        m1_awvalid = 1'b0, m1_awready, m1_wvalid = 1'b0, m1_wready;
  logic        m1_bvalid, m1_bready = 1'b1;
  logic [31:0] s_araddr, s_rdata = '0, s_rresp = '0, s_awaddr, s_wdata, s_bresp = '0;
  logic [3:0]  s_wstrb;
  logic        s_arvalid, s_arready = 1'b0, s_rvalid = 1'b0, s_rready;
  logic        s_awvalid, s_awready = 1'b0, s_wvalid, s_wready = 1'b0;
  logic        s_bvalid = 1'b0, s_bready;
  logic [1:0]  st_dbg;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_23060075_axi_arbiter #(.DATA_WIDTH(32), .MASK_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .st_dbg(st_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // OR-reductions of output groups, for "everything is zero" checks
  logic any_out, any_m1_out;
  assign any_m1_out = |{m1_arready, m1_rdata, m1_rresp, m1_rvalid, m1_awready, m1_wready,
                        m1_bresp, m1_bvalid};
  assign any_out = any_m1_out | (|{m0_arready, m0_rdata, m0_rresp, m0_rvalid, s_araddr,
                        s_arvalid, s_rready, s_awaddr, s_awvalid, s_wdata, s_wstrb,
                        s_wvalid, s_bready});

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Slave side of a read already granted to master `who`: AR accept, then one R beat.
  task automatic serve_read(input int who, input logic [31:0] data);
    s_arready = 1'b1;
    #1;
    check("rd_arready", (who == 0) ? m0_arready : m1_arready, 1);
    tick();
    s_arready = 1'b0;
    if (who == 0) m0_arvalid = 1'b0; else m1_arvalid = 1'b0;
    s_rvalid = 1'b1;
    s_rdata  = data;
    #1;
    check("rd_rdata", (who == 0) ? m0_rdata : m1_rdata, data);
    check("rd_rvalid_other", (who == 0) ? m1_rvalid : m0_rvalid, 0);
    tick();
    s_rvalid = 1'b0;
    s_rdata  = '0;
    #1;
    check("rd_idle_after", st_dbg, IDLE);
  endtask

  // Slave side of a write already granted to m1: AW+W accept, then B.
  task automatic serve_write(input logic [31:0] resp);
    s_awready = 1'b1;
    s_wready  = 1'b1;
    tick();
    s_awready  = 1'b0;
    s_wready   = 1'b0;
    m1_awvalid = 1'b0;
    m1_wvalid  = 1'b0;
    s_bvalid   = 1'b1;
    s_bresp    = resp;
    #1;
    check("wr_bvalid", m1_bvalid, 1);
    check("wr_bresp", m1_bresp, resp);
    tick();
    s_bvalid = 1'b0;
    s_bresp  = '0;
    #1;
    check("wr_idle_after", st_dbg, IDLE);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset: outputs all zero even with a request pending
    m0_arvalid = 1'b1;
    m0_araddr  = 32'h1234_5678;
    tick();
    tick();
    #1;
    check("reset_st", st_dbg, IDLE);
    check("reset_outputs_zero", any_out, 0);
    m0_arvalid = 1'b0;
    rst = 1'b0;
    tick();

    // 1: m0 read, data two cycles after AR accept
    m0_araddr  = 32'h8000_0000;
    m0_arvalid = 1'b1;
    #1;
    check("t1_idle_no_fwd", s_arvalid, 0);
    tick();
    #1;
    check("t1_st_g0r", st_dbg, G0R);
    check("t1_s_araddr", s_araddr, 32'h8000_0000);
    check("t1_s_arvalid", s_arvalid, 1);
    s_arready = 1'b1;
    tick();
    s_arready  = 1'b0;
    m0_arvalid = 1'b0;
    #1;
    check("t1_hold_after_ar", st_dbg, G0R);
    tick();
    s_rvalid = 1'b1;
    s_rdata  = 32'h0000_0413;
    #1;
    check("t1_m0_rdata", m0_rdata, 32'h0000_0413);
    check("t1_m0_rvalid", m0_rvalid, 1);
    check("t1_m1_quiet", any_m1_out, 0);
    tick();
    s_rvalid = 1'b0;
    s_rdata  = '0;
    #1;
    check("t1_idle", st_dbg, IDLE);
    check("t1_m0_rdata_idle", m0_rdata, 0);

    // 2: m1 write, W accepted before AW
    m1_awaddr  = 32'ha000_03f8;
    m1_awvalid = 1'b1;
    m1_wdata   = 32'h41;
    m1_wstrb   = 4'b0001;
    m1_wvalid  = 1'b1;
    tick();
    #1;
    check("t2_st_g1w", st_dbg, G1W);
    check("t2_s_awaddr", s_awaddr, 32'ha000_03f8);
    check("t2_s_awvalid", s_awvalid, 1);
    check("t2_s_wdata", s_wdata, 32'h41);
    check("t2_s_wstrb", s_wstrb, 4'b0001);
    check("t2_s_arvalid", s_arvalid, 0);
    s_wready = 1'b1;
    #1;
    check("t2_m1_wready", m1_wready, 1);
    check("t2_m1_awready_lo", m1_awready, 0);
    tick();
    s_wready  = 1'b0;
    m1_wvalid = 1'b0;
    s_awready = 1'b1;
    #1;
    check("t2_m1_awready", m1_awready, 1);
    check("t2_s_wvalid_lo", s_wvalid, 0);
    tick();
    s_awready  = 1'b0;
    m1_awvalid = 1'b0;
    #1;
    check("t2_hold_after_aw", st_dbg, G1W);
    s_bvalid = 1'b1;
    s_bresp  = 32'h2;
    #1;
    check("t2_m1_bvalid", m1_bvalid, 1);
    check("t2_m1_bresp", m1_bresp, 32'h2);
    check("t2_s_bready", s_bready, 1);
    tick();
    s_bvalid = 1'b0;
    s_bresp  = '0;
    #1;
    check("t2_idle", st_dbg, IDLE);
    check("t2_m1_bvalid_idle", m1_bvalid, 0);

    // 3: contention out of reset, then m0 re-requests while m1 still waits
    do_reset();
    m0_araddr  = 32'h8000_0010;
    m0_arvalid = 1'b1;
    m1_araddr  = 32'h8000_0020;
    m1_arvalid = 1'b1;
    tick();
    #1;
    check("t3_first_g0r", st_dbg, G0R);
    check("t3_first_addr", s_araddr, 32'h8000_0010);
    check("t3_m1_arready_blocked", m1_arready, 0);
    serve_read(0, 32'h1111_0000);
    m0_araddr  = 32'h8000_0030;
    m0_arvalid = 1'b1;
    tick();
    #1;
    check("t3_rr_g1r", st_dbg, G1R);
    check("t3_rr_addr", s_araddr, 32'h8000_0020);
    serve_read(1, 32'h2222_0000);
    tick();
    #1;
    check("t3_third_g0r", st_dbg, G0R);
    check("t3_third_addr", s_araddr, 32'h8000_0030);
    serve_read(0, 32'h3333_0000);

    // 4: m1 arvalid and awvalid together -> read first, then write
    m1_araddr  = 32'h8000_0040;
    m1_arvalid = 1'b1;
    m1_awaddr  = 32'h8000_0044;
    m1_awvalid = 1'b1;
    m1_wdata   = 32'hdead_beef;
    m1_wstrb   = 4'b1111;
    m1_wvalid  = 1'b1;
    tick();
    #1;
    check("t4_read_first", st_dbg, G1R);
    check("t4_s_awvalid_lo", s_awvalid, 0);
    check("t4_s_wvalid_lo", s_wvalid, 0);
    serve_read(1, 32'h4444_0000);
    tick();
    #1;
    check("t4_then_write", st_dbg, G1W);
    check("t4_s_awaddr", s_awaddr, 32'h8000_0044);
    serve_write(32'h0);

    // 5: R back-pressure on m1 holds the grant with m0 pending
    m1_araddr  = 32'h8000_0050;
    m1_arvalid = 1'b1;
    m1_rready  = 1'b0;
    tick();
    m0_araddr  = 32'h8000_0060;
    m0_arvalid = 1'b1;
    s_arready  = 1'b1;
    tick();
    s_arready  = 1'b0;
    m1_arvalid = 1'b0;
    s_rvalid   = 1'b1;
    s_rdata    = 32'h5555_0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t5_held_g1r", st_dbg, G1R);
      check("t5_s_rready_lo", s_rready, 0);
      check("t5_m0_arready_lo", m0_arready, 0);
      tick();
    end
    m1_rready = 1'b1;
    #1;
    check("t5_s_rready_hi", s_rready, 1);
    check("t5_still_g1r", st_dbg, G1R);
    tick();
    s_rvalid = 1'b0;
    s_rdata  = '0;
    #1;
    check("t5_idle", st_dbg, IDLE);
    tick();
    #1;
    check("t5_m0_granted", st_dbg, G0R);
    check("t5_m0_addr", s_araddr, 32'h8000_0060);
    serve_read(0, 32'h6666_0000);

    // 6: reset during G1W after AW accept, before B
    m1_awaddr  = 32'h8000_0070;
    m1_awvalid = 1'b1;
    m1_wdata   = 32'h77;
    m1_wstrb   = 4'b0011;
    m1_wvalid  = 1'b1;
    tick();
    #1;
    check("t6_g1w", st_dbg, G1W);
    s_awready = 1'b1;
    s_wready  = 1'b1;
    tick();
    s_awready  = 1'b0;
    s_wready   = 1'b0;
    m1_awvalid = 1'b0;
    m1_wvalid  = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s_bvalid = 1'b1;
    #1;
    check("t6_rst_idle", st_dbg, IDLE);
    check("t6_rst_outputs_zero", any_out, 0);
    s_bvalid   = 1'b0;
    m0_araddr  = 32'h8000_0080;
    m0_arvalid = 1'b1;
    tick();
    #1;
    check("t6_new_g0r", st_dbg, G0R);
    serve_read(0, 32'h8888_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
